// File: rtl/des_key_schedule.sv
// DES key schedule: streams the 16 round subkeys in encrypt or decrypt order with a valid/next handshake.
// Optional DES_KEY_PARITY_CHECK_EN adds an odd-parity check of each key byte on start.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        next,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned SH_IDX_W = 5;

  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // Table bit n (1-based, MSB first) maps to vector index W-n.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(KEY_W - PC1_TAB[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(CD_W - PC2_TAB[6'(i)])];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_e               state_q, state_d;
  logic [HALF_W-1:0]    c_q, c_d, d_q, d_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 dec_q, dec_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CD_W-1:0]      pc1_key;
  logic [SH_IDX_W-1:0]  sh_idx;
  logic                 sh_two;

  assign pc1_key = pc1(key);

  // Shift table index of the round being advanced to; SH is 1 only at 1, 2, 9, 16.
  assign sh_idx = dec_q ? SH_IDX_W'(5'd16 - {1'b0, round_q})
                        : SH_IDX_W'({1'b0, round_q} + 5'd2);
  assign sh_two = !((sh_idx == 5'd1) || (sh_idx == 5'd2) ||
                    (sh_idx == 5'd9) || (sh_idx == 5'd16));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dec_d   = decrypt;
          round_d = '0;
          state_d = ST_RUN;
          // Encrypt starts at K1 (one left shift); decrypt starts at K16 (net shift of 28).
          if (decrypt) begin
            c_d = pc1_key[55:28];
            d_d = pc1_key[27:0];
          end else begin
            c_d = rotl(pc1_key[55:28], 1'b0);
            d_d = rotl(pc1_key[27:0], 1'b0);
          end
        end
      end
      ST_RUN: begin
        if (next) begin
          if (round_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
            if (dec_q) begin
              c_d = rotr(c_q, sh_two);
              d_d = rotr(d_q, sh_two);
            end else begin
              c_d = rotl(c_q, sh_two);
              d_d = rotl(d_q, sh_two);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_q, par_d;

  // Flag any key byte with even parity; held until the next accepted start.
  always_comb begin
    par_d = par_q;
    if ((state_q == ST_IDLE) && start) begin
      par_d = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (!(^key[6'(8 * b) +: 8])) par_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

  assign subkey       = pc2({c_q, d_q});
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed sequences with random handshake and key noise, checked against a from-scratch DES key schedule model.
module tb_des_key_schedule;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

`ifdef DES_KEY_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic        next;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        parity_err;

  int checks   = 0;
  int failures = 0;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .next         (next),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // DES Ki computed directly: PC-1, cumulative left rotation of sum(SH[1..i]), PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int i);
    logic [56:1] cd;
    logic [56:1] cr;
    logic [47:0] res;
    int s;
    s = 0;
    for (int r = 0; r < i; r++) s += SH[r];
    for (int j = 1; j <= 56; j++) cd[6'(j)] = k[6'(64 - PC1[j - 1])];
    for (int j = 1; j <= 28; j++) begin
      cr[6'(j)]      = cd[6'(((j - 1 + s) % 28) + 1)];
      cr[6'(28 + j)] = cd[6'(28 + ((j - 1 + s) % 28) + 1)];
    end
    res = '0;
    for (int j = 1; j <= 48; j++) res[6'(48 - j)] = cr[6'(PC2[j - 1])];
    return res;
  endfunction

  function automatic logic ref_parity(input logic [63:0] k);
    logic       bad;
    logic [7:0] by;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      by = 8'(k >> (8 * b));
      if ((^by) == 1'b0) bad = 1'b1;
    end
    return bad & PAR_EN;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full sequence; rand_next toggles the handshake, disturb re-pulses start with another key at round 5.
  task automatic run_seq(input logic [63:0] k, input logic dec, input bit rand_next,
                         input bit disturb, output logic [47:0] first, output logic [47:0] last);
    int   cnt;
    logic nx;
    cnt   = 0;
    first = '0;
    last  = '0;
    @(negedge clk);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    next    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && cnt < 16; cyc++) begin
      check("valid", 64'(subkey_valid), 64'(1));
      check("busy", 64'(busy), 64'(1));
      check("done_run", 64'(done), 64'(0));
      check("parity", 64'(parity_err), 64'(ref_parity(k)));
      check("round", 64'(round), 64'(cnt));
      check("subkey", 64'(subkey), 64'(ref_subkey(k, dec ? 16 - cnt : cnt + 1)));
      if (cnt == 0) first = subkey;
      last    = subkey;
      start   = disturb && (cnt == 5);
      key     = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
      nx      = rand_next ? 1'($urandom_range(0, 1)) : 1'b1;
      next    = nx;
      @(negedge clk);
      if (nx) cnt++;
    end
    start = 1'b0;
    check("accepts", 64'(cnt), 64'(16));
    check("done_pulse", 64'(done), 64'(1));
    check("valid_done", 64'(subkey_valid), 64'(0));
    check("busy_done", 64'(busy), 64'(0));
    @(negedge clk);
    check("done_single", 64'(done), 64'(0));
    check("valid_idle", 64'(subkey_valid), 64'(0));
    check("parity_hold", 64'(parity_err), 64'(ref_parity(k)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    logic [47:0] l;
    logic [63:0] rk;
    rst_n   = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    key     = '0;
    next    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(subkey_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_parity", 64'(parity_err), 64'(0));
    check("rst_round", 64'(round), 64'(0));
    check("rst_subkey", 64'(subkey), 64'(0));
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // next while idle must be ignored
    next = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 64'(subkey_valid), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));

    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, f, l);
    check("enc_first_vec", 64'(f), 64'(K1_A));
    check("enc_last_vec", 64'(l), 64'(K16_A));

    run_seq(KEY_A, 1'b1, 1'b0, 1'b0, f, l);
    check("dec_first_vec", 64'(f), 64'(K16_A));
    check("dec_last_vec", 64'(l), 64'(K1_A));

    run_seq(KEY_A, 1'b0, 1'b1, 1'b0, f, l);
    check("rand_first_vec", 64'(f), 64'(K1_A));
    check("rand_last_vec", 64'(l), 64'(K16_A));

    run_seq(KEY_A, 1'b0, 1'b1, 1'b1, f, l);
    check("disturb_last_vec", 64'(l), 64'(K16_A));

    // Reset in the middle of a sequence
    @(negedge clk);
    start   = 1'b1;
    key     = KEY_A;
    decrypt = 1'b0;
    next    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_round", 64'(round), 64'(8));
    check("pre_rst_subkey", 64'(subkey), 64'(ref_subkey(KEY_A, 9)));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(subkey_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_round", 64'(round), 64'(0));
    check("mid_rst_subkey", 64'(subkey), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_done", 64'(done), 64'(0));
      check("post_rst_valid", 64'(subkey_valid), 64'(0));
    end
    run_seq(KEY_A, 1'b0, 1'b0, 1'b0, f, l);
    check("post_rst_first_vec", 64'(f), 64'(K1_A));

    // Parity: all-zero key has even-parity bytes
    run_seq(64'h0, 1'b0, 1'b0, 1'b0, f, l);
    check("zero_key_subkey", 64'(f), 64'(0));
    run_seq(KEY_A, 1'b1, 1'b1, 1'b0, f, l);

    for (int t = 0; t < 4; t++) begin
      rk = {$urandom, $urandom};
      run_seq(rk, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), f, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
